gpio_in_irq_ctrl: RTL

GPIO_IN_IRQ_CTRL -- requirements
Module: gpio_in_irq_ctrl

---
 rtl/gpio_in_irq_ctrl.sv | 139 +++++++++++++
 1 files changed

// File: rtl/gpio_in_irq_ctrl.sv
// GPIO input block: synchronized pins, rising-edge capture (W1C), interrupt mask, level irq.
// Optional per-pin debounce is compiled in when GPIO_IN_DEBOUNCE_EN is defined.
module gpio_in_irq_ctrl #(
    parameter int          WIDTH    = 8,
    parameter logic [15:0] DB_RESET = 16'd50000
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             write,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);

    logic [WIDTH-1:0] r_sync1;
    logic [WIDTH-1:0] r_sync2;
    logic [WIDTH-1:0] r_din;
    logic [WIDTH-1:0] r_mask;
    logic [WIDTH-1:0] r_cap;
    logic             r_irq;
    logic [31:0]      r_rdata;

    logic             w_wr_mask;
    logic             w_wr_cap;
    logic [WIDTH-1:0] w_w1c;
    logic [WIDTH-1:0] w_din_next;
    logic [WIDTH-1:0] w_cap_next;
    logic [31:0]      w_rd_next;
    logic [31:0]      w_dbp_rd;
    logic             w_unused_wd;

    assign w_wr_mask   = write && (address == 2'd1);
    assign w_wr_cap    = write && (address == 2'd2);
    assign w_w1c       = w_wr_cap ? writedata[WIDTH-1:0] : '0;
    assign w_unused_wd = ^writedata;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= in_port;
            r_sync2 <= r_sync1;
        end
    end

`ifdef GPIO_IN_DEBOUNCE_EN
    logic [15:0]           r_dbp;
    logic [15:0]           r_pre;
    logic [WIDTH-1:0][1:0] r_cnt;
    logic [WIDTH-1:0][1:0] w_cnt_next;
    logic [15:0]           w_dbp_eff;
    logic                  w_tick;
    logic                  w_wr_dbp;

    assign w_wr_dbp  = write && (address == 2'd3);
    assign w_dbp_eff = (r_dbp == 16'd0) ? 16'd1 : r_dbp;
    // >= keeps the prescaler from running away if the period shrinks under it
    assign w_tick    = (r_pre >= (w_dbp_eff - 16'd1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_dbp <= DB_RESET;
            r_pre <= '0;
            r_cnt <= '0;
        end else begin
            r_cnt <= w_cnt_next;
            if (w_wr_dbp) begin
                r_dbp <= writedata[15:0];
                r_pre <= '0;
            end else if (w_tick) begin
                r_pre <= '0;
            end else begin
                r_pre <= r_pre + 16'd1;
            end
        end
    end

    // A bit flips only after three consecutive tick samples all differ from din.
    always_comb begin
        w_din_next = r_din;
        w_cnt_next = r_cnt;
        if (w_tick) begin
            for (int i = 0; i < WIDTH; i++) begin
                if (r_sync2[i] == r_din[i]) begin
                    w_cnt_next[i] = 2'd0;
                end else if (r_cnt[i] == 2'd2) begin
                    w_din_next[i] = r_sync2[i];
                    w_cnt_next[i] = 2'd0;
                end else begin
                    w_cnt_next[i] = r_cnt[i] + 2'd1;
                end
            end
        end
    end

    assign w_dbp_rd = {16'd0, r_dbp};
`else
    assign w_din_next = r_sync2;
    assign w_dbp_rd   = '0;
`endif

    // Rising edges are taken from the din update itself, so a set beats a same-cycle clear.
    assign w_cap_next = (r_cap & ~w_w1c) | (w_din_next & ~r_din);

    always_comb begin
        w_rd_next = '0;
        case (address)
            2'd0:    w_rd_next[WIDTH-1:0] = r_din;
            2'd1:    w_rd_next[WIDTH-1:0] = r_mask;
            2'd2:    w_rd_next[WIDTH-1:0] = r_cap;
            default: w_rd_next = w_dbp_rd;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_din   <= '0;
            r_mask  <= '0;
            r_cap   <= '0;
            r_irq   <= 1'b0;
            r_rdata <= '0;
        end else begin
            r_din   <= w_din_next;
            r_cap   <= w_cap_next;
            r_irq   <= |(r_cap & r_mask);
            r_rdata <= w_rd_next;
            if (w_wr_mask) begin
                r_mask <= writedata[WIDTH-1:0];
            end
        end
    end

    assign readdata = r_rdata;
    assign irq      = r_irq;

endmodule
